// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle core: default bus widths and the
// memory-bridge FSM encoding.
package mips_pkg;

  localparam int MIPS_ADDR_W = 32;
  localparam int MIPS_DATA_W = 32;

  localparam logic [1:0] MB_IDLE = 2'd0;
  localparam logic [1:0] MB_REQ  = 2'd1;
  localparam logic [1:0] MB_DONE = 2'd2;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mem_bridge_timer.sv
// Wait-state counter for the memory bridge; o_expired flags the last REQ
// cycle the bridge may spend waiting for an acknowledge.
module mem_bridge_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  // Count REQ cycles without ack; cleared whenever the bridge is not in REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= {CW{1'b0}};
    end else if (i_clr) begin
      r_count <= {CW{1'b0}};
    end else if (i_en) begin
      r_count <= r_count + CW'(1);
    end
  end

  // The count lags the REQ cycle number by one, so TIMEOUT-1 marks the final cycle.
  assign o_expired = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bridge.sv
// Multicycle-core memory bridge: converts the controller's level-held memory
// controls into one req/ack bus transaction and owns the IR and MDR.
module mem_bridge
  import mips_pkg::*;
#(
  parameter int ADDR_W  = MIPS_ADDR_W,
  parameter int DATA_W  = MIPS_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ir_write,
  input  logic              iord,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] mdr,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  logic              w_acc;
  logic [ADDR_W-1:0] w_addr;
  logic              w_aligned;
  logic              w_expired;
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_mdr;
  logic              r_err;

  assign w_acc     = mem_read | mem_write;
  assign w_addr    = iord ? alu_out : pc;
  assign w_aligned = word_aligned(w_addr[1:0]);

  mem_bridge_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (r_state != MB_REQ),
    .i_en      ((r_state == MB_REQ) & ~bus_ack),
    .o_expired (w_expired)
  );

  // Next-state logic; misaligned requests skip the bus and go straight to DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MB_IDLE: begin
        if (w_acc) begin
          w_state_nxt = w_aligned ? MB_REQ : MB_DONE;
        end else begin
          w_state_nxt = MB_IDLE;
        end
      end
      MB_REQ: begin
        if (bus_ack || w_expired) begin
          w_state_nxt = MB_DONE;
        end else begin
          w_state_nxt = MB_REQ;
        end
      end
      MB_DONE: w_state_nxt = MB_IDLE;
      default: w_state_nxt = MB_IDLE;
    endcase
  end

  // State, bus request registers, IR/MDR and the sticky fault flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= MB_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= {ADDR_W{1'b0}};
      r_bus_wdata <= {DATA_W{1'b0}};
      r_instr     <= {DATA_W{1'b0}};
      r_mdr       <= {DATA_W{1'b0}};
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        MB_IDLE: begin
          if (w_acc && w_aligned) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= mem_write;
            r_bus_addr  <= w_addr;
            r_bus_wdata <= wdata;
            // Read and write together resolves to a write but is still a fault.
            if (mem_read && mem_write) begin
              r_err <= 1'b1;
            end
          end else if (w_acc) begin
            r_err <= 1'b1;
          end
        end
        MB_REQ: begin
          if (bus_ack) begin
            r_bus_req <= 1'b0;
            if (!r_bus_we) begin
              r_mdr <= bus_rdata;
              if (ir_write) begin
                r_instr <= bus_rdata;
              end
            end
          end else if (w_expired) begin
            r_bus_req <= 1'b0;
            r_err     <= 1'b1;
          end
        end
        default: r_bus_req <= 1'b0;
      endcase
    end
  end

  assign stall     = w_acc & (r_state != MB_DONE);
  assign instr     = r_instr;
  assign mdr       = r_mdr;
  assign err       = r_err;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge: a transaction-level model predicts each
// access outcome and bus transaction; negedge monitors compare them.
module tb_mem_bridge;

  localparam int TO = 4;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] mdr;
    logic        err;
    int          stall_n;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0, ir_write = 1'b0, iord = 1'b0;
  logic [31:0] pc = 32'd0, alu_out = 32'd0, wdata = 32'd0, bus_rdata = 32'd0;
  logic        bus_ack = 1'b0;
  logic        stall, err, bus_req, bus_we;
  logic [31:0] instr, mdr, bus_addr, bus_wdata;

  exp_t exp_q[$];
  bus_t bus_q[$];
  logic [31:0] m_instr = 32'd0, m_mdr = 32'd0;
  logic        m_err = 1'b0;
  int n_checks = 0, n_fail = 0;
  int last_gap = 0;

  mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .iord(iord), .pc(pc), .alu_out(alu_out), .wdata(wdata),
    .stall(stall), .instr(instr), .mdr(mdr), .err(err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Completion monitor: an access finishes in the cycle stall drops while requested.
  initial begin
    int   stall_cnt;
    exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_cnt = 0;
      end else if (mem_read || mem_write) begin
        if (stall) begin
          stall_cnt++;
        end else begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_completion: got completion, expected none");
          end else begin
            e = exp_q.pop_front();
            chk("instr", instr, e.instr);
            chk("mdr", mdr, e.mdr);
            chk("err", {31'd0, err}, {31'd0, e.err});
            chk("stall_cycles", stall_cnt, e.stall_n);
          end
          stall_cnt = 0;
        end
      end
    end
  end

  // Bus monitor: each bus_req pulse must match the next predicted transaction and stay stable.
  initial begin
    logic prev_req;
    int   low_cnt;
    bus_t b;
    prev_req = 1'b0;
    low_cnt  = 0;
    forever begin
      @(negedge clk);
      if (bus_req && !prev_req) begin
        last_gap = low_cnt;
        low_cnt  = 0;
        if (bus_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_bus_req: got bus_req at addr %h, expected none", bus_addr);
        end else begin
          b = bus_q.pop_front();
          chk("bus_addr", bus_addr, b.addr);
          chk("bus_we", {31'd0, bus_we}, {31'd0, b.we});
          chk("bus_wdata", bus_wdata, b.wdata);
        end
      end else if (bus_req) begin
        chk("bus_addr_stable", bus_addr, b.addr);
        chk("bus_we_stable", {31'd0, bus_we}, {31'd0, b.we});
        chk("bus_wdata_stable", bus_wdata, b.wdata);
      end else begin
        low_cnt++;
      end
      prev_req = bus_req;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; ir_write = 1'b0; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_instr = 32'd0; m_mdr = 32'd0; m_err = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; ir_write = 1'b0;
  endtask

  // One controller memory state: predict the outcome, then act as controller and bus.
  task automatic do_access(input logic rd, input logic wr, input logic irw, input logic sel,
                           input logic [31:0] pc_i, input logic [31:0] alu_i,
                           input logic [31:0] wd_i, input logic [31:0] rdat,
                           input int wait_n, input logic ack_en);
    logic [31:0] a;
    exp_t e;
    bus_t b;
    int   req_n;
    bit   done;
    a = sel ? alu_i : pc_i;
    if (a[1:0] != 2'b00) begin
      m_err = 1'b1;
      e.stall_n = 1;
    end else begin
      b.addr = a; b.we = wr; b.wdata = wd_i;
      bus_q.push_back(b);
      if (rd && wr) m_err = 1'b1;
      if (ack_en && wait_n < TO) begin
        e.stall_n = 2 + wait_n;
        if (!wr) begin
          m_mdr = rdat;
          if (irw) m_instr = rdat;
        end
      end else begin
        m_err = 1'b1;
        e.stall_n = 1 + TO;
      end
    end
    e.instr = m_instr; e.mdr = m_mdr; e.err = m_err;
    exp_q.push_back(e);

    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; ir_write = irw; iord = sel;
    pc = pc_i; alu_out = alu_i; wdata = wd_i;
    req_n = 0;
    done  = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (bus_req) begin
        req_n++;
        if (ack_en && req_n == wait_n + 1) begin
          bus_ack = 1'b1; bus_rdata = rdat;
        end else begin
          bus_ack = 1'b0; bus_rdata = $urandom;
        end
      end else begin
        bus_ack = ($urandom_range(0, 3) == 0);
        bus_rdata = $urandom;
      end
      if (!stall) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL access_timeout: got stall still high after 200 cycles, expected release");
    end
  endtask

  initial begin
    bus_t b;
    logic rd, wr, irw, sel, ack_en;
    logic [31:0] pc_i, alu_i;
    int   s;

    do_reset();
    #2;
    chk("rst_instr", instr, 32'd0);
    chk("rst_mdr", mdr, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);

    do_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 32'h8C220004, 0, 1'b1);
    do_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h44, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1'b1);
    do_access(1'b0, 1'b1, 1'b0, 1'b1, 32'h48, 32'h204, 32'h1234, 32'h55AA55AA, 2, 1'b1);
    do_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h48, 32'h204, 32'h0, 32'h00001111, 1, 1'b1);
    chk("b2b_idle_gap", last_gap, 2);
    idle_cycle();
    do_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h4C, 32'h102, 32'h0, 32'h0, 0, 1'b1);

    do_reset();
    do_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h50, 32'h300, 32'h0, 32'h0, 0, 1'b0);

    do_reset();
    do_access(1'b1, 1'b1, 1'b0, 1'b1, 32'h54, 32'h310, 32'hCAFE0001, 32'h0, 1, 1'b1);

    // Reset in the middle of REQ, then a late ack that must be ignored.
    do_reset();
    b.addr = 32'h80; b.we = 1'b0; b.wdata = 32'd0;
    bus_q.push_back(b);
    @(posedge clk); #1;
    wdata = 32'd0; iord = 1'b0; pc = 32'h80; mem_read = 1'b1; ir_write = 1'b1; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("midrst_bus_addr", bus_addr, 32'd0);
    reset = 1'b0; mem_read = 1'b0; ir_write = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hBADBAD00;
    repeat (2) @(posedge clk);
    #1 bus_ack = 1'b0;
    chk("midrst_instr", instr, 32'd0);
    chk("midrst_mdr", mdr, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    m_instr = 32'd0; m_mdr = 32'd0; m_err = 1'b0;

    for (int k = 0; k < 80; k++) begin
      s   = $urandom_range(0, 9);
      rd  = (s <= 5) || (s == 9);
      wr  = (s >= 6);
      irw = rd && !wr && ($urandom_range(0, 1) == 1);
      sel = ($urandom_range(0, 1) == 1);
      pc_i  = $urandom;
      alu_i = $urandom;
      if ($urandom_range(0, 7) != 0) pc_i[1:0] = 2'b00;
      if ($urandom_range(0, 7) != 0) alu_i[1:0] = 2'b00;
      ack_en = ($urandom_range(0, 7) != 0);
      do_access(rd, wr, irw, sel, pc_i, alu_i, $urandom, $urandom, $urandom_range(0, 3), ack_en);
      if ($urandom_range(0, 3) == 0) idle_cycle();
      if (k % 20 == 19) do_reset();
    end

    idle_cycle();
    repeat (3) @(posedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("bus_q_drained", bus_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
